// File: rtl/nexys_video_basic_io_pkg.sv
// Shared constants for the Nexys Video basic-IO path: default board sizes,
// default debounce window and push-button index names.
package nexys_video_basic_io_pkg;

  localparam int DEF_N_BUTTONS       = 5;
  localparam int DEF_N_SWITCHES      = 8;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms at 100 MHz

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/nexys_video_debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter, accepted level and
// registered rise/fall pulses. A single cycle where the synchronised input
// matches the accepted level restarts the stability window.
module nexys_video_debounce_bit
  import nexys_video_basic_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_q;
  logic                 r_rise;
  logic                 r_fall;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  assign w_diff = (r_s2 != r_q);
  assign w_done = (r_cnt == CNT_MAX);

  // Synchronise, count consecutive differing cycles, accept after the window
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_q    <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_q    <= r_s2;
        r_cnt  <= '0;
        r_rise <= r_s2;
        r_fall <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_q;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/nexys_video_input_conditioner.sv
// Conditions raw Nexys Video buttons and switches for the basic-IO core:
// per-bit debounce, press/release/change pulses, and write-1-to-clear sticky
// press flags where a simultaneous press keeps the flag set.
module nexys_video_input_conditioner
  import nexys_video_basic_io_pkg::*;
#(
  parameter int N_BUTTONS       = DEF_N_BUTTONS,
  parameter int N_SWITCHES      = DEF_N_SWITCHES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [N_BUTTONS-1:0]  i_buttons_raw,
  input  logic [N_SWITCHES-1:0] i_switches_raw,
  output logic [N_BUTTONS-1:0]  o_buttons,
  output logic [N_SWITCHES-1:0] o_switches,
  output logic [N_BUTTONS-1:0]  o_btn_press,
  output logic [N_BUTTONS-1:0]  o_btn_release,
  output logic [N_SWITCHES-1:0] o_sw_change,
  output logic [N_BUTTONS-1:0]  o_btn_sticky,
  input  logic [N_BUTTONS-1:0]  i_btn_clear
);

  logic [N_SWITCHES-1:0] w_sw_rise;
  logic [N_SWITCHES-1:0] w_sw_fall;
  logic [N_BUTTONS-1:0]  r_sticky;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
    nexys_video_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_db (
      .aclk    (aclk),
      .areset  (areset),
      .i_raw   (i_buttons_raw[gi]),
      .o_level (o_buttons[gi]),
      .o_rise  (o_btn_press[gi]),
      .o_fall  (o_btn_release[gi])
    );
  end

  for (genvar gi = 0; gi < N_SWITCHES; gi++) begin : g_sw
    nexys_video_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_db (
      .aclk    (aclk),
      .areset  (areset),
      .i_raw   (i_switches_raw[gi]),
      .o_level (o_switches[gi]),
      .o_rise  (w_sw_rise[gi]),
      .o_fall  (w_sw_fall[gi])
    );
  end

  // Both inputs to the OR are registered one-cycle pulses, so the change
  // pulse is glitch-free and lasts exactly one cycle.
  assign o_sw_change = w_sw_rise | w_sw_fall;

  // Sticky press flags: clear by write-1, a same-cycle press wins
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= (r_sticky & ~i_btn_clear) | o_btn_press;
    end
  end

  assign o_btn_sticky = r_sticky;

endmodule

// File: tb/tb_nexys_video_input_conditioner.sv
// Directed bench for nexys_video_input_conditioner with a short debounce
// window. Expected output values are queued with the cycle they are due and
// compared when the run reaches that cycle.
module tb_nexys_video_input_conditioner;
  import nexys_video_basic_io_pkg::*;

  localparam int NB = 5;
  localparam int NS = 8;
  localparam int DC = 4;

  localparam int S_BTN = 0;
  localparam int S_SW  = 1;
  localparam int S_PRS = 2;
  localparam int S_REL = 3;
  localparam int S_CHG = 4;
  localparam int S_STK = 5;

  logic          aclk;
  logic          areset;
  logic [NB-1:0] i_buttons_raw;
  logic [NS-1:0] i_switches_raw;
  logic [NB-1:0] o_buttons;
  logic [NS-1:0] o_switches;
  logic [NB-1:0] o_btn_press;
  logic [NB-1:0] o_btn_release;
  logic [NS-1:0] o_sw_change;
  logic [NB-1:0] o_btn_sticky;
  logic [NB-1:0] i_btn_clear;

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  nexys_video_input_conditioner #(
    .N_BUTTONS       (NB),
    .N_SWITCHES      (NS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .i_buttons_raw  (i_buttons_raw),
    .i_switches_raw (i_switches_raw),
    .o_buttons      (o_buttons),
    .o_switches     (o_switches),
    .o_btn_press    (o_btn_press),
    .o_btn_release  (o_btn_release),
    .o_sw_change    (o_sw_change),
    .o_btn_sticky   (o_btn_sticky),
    .i_btn_clear    (i_btn_clear)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      S_BTN:   return {3'b000, o_buttons};
      S_SW:    return o_switches;
      S_PRS:   return {3'b000, o_btn_press};
      S_REL:   return {3'b000, o_btn_release};
      S_CHG:   return o_sw_change;
      default: return {3'b000, o_btn_sticky};
    endcase
  endfunction

  task automatic expect_at(input int at, input int sel, input logic [7:0] val,
                           input string tag);
    exp_t e;
    e.at  = at;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input int at, input string tag);
    for (int s = 0; s < 6; s++) expect_at(at, s, 8'h00, tag);
  endtask

  task automatic check_due();
    exp_t keep[$];
    logic [7:0] o;
    foreach (sb[i]) begin
      if (sb[i].at == cyc) begin
        o = obs(sb[i].sel);
        checks++;
        assert (o === sb[i].val) else begin
          errors++;
          $error("FAIL %s sel=%0d cyc=%0d observed=%h expected=%h",
                 sb[i].tag, sb[i].sel, cyc, o, sb[i].val);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
    cyc++;
    check_due();
  endtask

  initial begin
    int k, m, p, r, s, t;
    logic [7:0] seq;

    cyc            = 0;
    checks         = 0;
    errors         = 0;
    areset         = 1'b1;
    i_buttons_raw  = '0;
    i_switches_raw = '0;
    i_btn_clear    = '0;

    // Reset state
    expect_all_zero(1, "reset_c1");
    expect_all_zero(2, "reset_c2");
    tick();
    tick();
    areset = 1'b0;
    for (int c = 1; c <= 20; c++) expect_all_zero(cyc + c, "idle_after_reset");
    repeat (20) tick();

    // BTN_U press, then release with a concurrent sticky clear
    k = cyc;
    i_buttons_raw[BTN_U] = 1'b1;
    expect_at(k + 5, S_BTN, 8'h00, "btnu_level_early");
    expect_at(k + 5, S_PRS, 8'h00, "btnu_press_early");
    expect_at(k + 6, S_BTN, 8'h02, "btnu_level");
    expect_at(k + 6, S_PRS, 8'h02, "btnu_press");
    expect_at(k + 6, S_STK, 8'h00, "btnu_sticky_early");
    expect_at(k + 7, S_PRS, 8'h00, "btnu_press_once");
    expect_at(k + 7, S_STK, 8'h02, "btnu_sticky");
    expect_at(k + 7, S_BTN, 8'h02, "btnu_level_hold");
    repeat (10) tick();
    i_buttons_raw[BTN_U] = 1'b0;
    i_btn_clear[BTN_U]   = 1'b1;
    expect_at(k + 11, S_STK, 8'h00, "btnu_sticky_clr");
    expect_at(k + 15, S_BTN, 8'h02, "btnu_rel_early");
    expect_at(k + 15, S_REL, 8'h00, "btnu_relp_early");
    expect_at(k + 16, S_BTN, 8'h00, "btnu_rel_level");
    expect_at(k + 16, S_REL, 8'h02, "btnu_release");
    expect_at(k + 17, S_REL, 8'h00, "btnu_release_once");
    tick();
    i_btn_clear = '0;
    repeat (7) tick();

    // Switch 3 bounce: 1,1,1,0 then a steady run of 1s
    m   = cyc;
    seq = 8'b1111_0111;
    expect_at(m + 6,  S_SW,  8'h00, "sw3_glitch_hold");
    expect_at(m + 6,  S_CHG, 8'h00, "sw3_glitch_nochg");
    expect_at(m + 7,  S_SW,  8'h00, "sw3_restart");
    expect_at(m + 9,  S_SW,  8'h00, "sw3_early");
    expect_at(m + 9,  S_CHG, 8'h00, "sw3_chg_early");
    expect_at(m + 10, S_SW,  8'h08, "sw3_level");
    expect_at(m + 10, S_CHG, 8'h08, "sw3_change");
    expect_at(m + 11, S_CHG, 8'h00, "sw3_change_once");
    expect_at(m + 11, S_SW,  8'h08, "sw3_level_hold");
    for (int i = 0; i < 8; i++) begin
      i_switches_raw[3] = seq[i];
      tick();
    end
    repeat (4) tick();

    // Button 0 held for 20 cycles, then released
    p = cyc;
    i_buttons_raw[BTN_C] = 1'b1;
    expect_at(p + 6,  S_PRS, 8'h01, "b0_press");
    expect_at(p + 6,  S_BTN, 8'h01, "b0_level");
    expect_at(p + 7,  S_PRS, 8'h00, "b0_press_once");
    expect_at(p + 7,  S_STK, 8'h01, "b0_sticky");
    expect_at(p + 25, S_BTN, 8'h01, "b0_rel_early");
    expect_at(p + 25, S_REL, 8'h00, "b0_relp_early");
    expect_at(p + 26, S_REL, 8'h01, "b0_release");
    expect_at(p + 26, S_BTN, 8'h00, "b0_rel_level");
    expect_at(p + 27, S_REL, 8'h00, "b0_release_once");
    repeat (20) tick();
    i_buttons_raw[BTN_C] = 1'b0;
    repeat (8) tick();

    // Sticky clear, then clear coincident with a new press (press wins)
    r = cyc;
    i_btn_clear[BTN_C] = 1'b1;
    expect_at(r + 1, S_STK, 8'h00, "b0_sticky_clr1");
    tick();
    i_btn_clear = '0;
    s = cyc;
    i_buttons_raw[BTN_C] = 1'b1;
    expect_at(s + 6, S_PRS, 8'h01, "b0_press2");
    expect_at(s + 6, S_STK, 8'h00, "b0_sticky_pre");
    expect_at(s + 7, S_STK, 8'h01, "b0_set_wins");
    expect_at(s + 8, S_STK, 8'h01, "b0_sticky_hold");
    repeat (6) tick();
    i_btn_clear[BTN_C] = 1'b1;
    tick();
    i_btn_clear = '0;
    repeat (3) tick();
    i_btn_clear[BTN_C] = 1'b1;
    expect_at(s + 11, S_STK, 8'h00, "b0_sticky_clr2");
    tick();
    i_btn_clear = '0;
    i_buttons_raw[BTN_C] = 1'b0;
    repeat (8) tick();

    // Reset while button 2 has a pending change with cnt == 2
    t = cyc;
    i_buttons_raw[BTN_L] = 1'b1;
    repeat (4) tick();
    areset = 1'b1;
    expect_all_zero(t + 5, "midcount_reset");
    tick();
    areset = 1'b0;
    expect_at(t + 8,  S_BTN, 8'h00, "b2_discarded");
    expect_at(t + 10, S_BTN, 8'h00, "b2_early");
    expect_at(t + 10, S_PRS, 8'h00, "b2_press_early");
    expect_at(t + 11, S_BTN, 8'h04, "b2_level");
    expect_at(t + 11, S_PRS, 8'h04, "b2_press");
    expect_at(t + 12, S_PRS, 8'h00, "b2_press_once");
    repeat (8) tick();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
